// File: rtl/seq_window_checker.sv
// seq_window_checker: per-channel monitor for "a, then c inside [MIN_DLY, MAX_DLY],
// then b one cycle later, with ce held high throughout". Purely observational.
// Reports pass/fail pulses, the code of the last failure, sticky error flags and
// saturating event totals across all channels.
module seq_window_checker #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned MIN_DLY = 1,
  parameter int unsigned MAX_DLY = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NCH-1:0]     i_a,
  input  logic [NCH-1:0]     i_c,
  input  logic [NCH-1:0]     i_b,
  input  logic [NCH-1:0]     i_ce,
  input  logic               i_clr,
  output logic [NCH-1:0]     o_pass_p,
  output logic [NCH-1:0]     o_fail_p,
  output logic [2*NCH-1:0]   o_fail_code,
  output logic [NCH-1:0]     o_err_sticky,
  output logic [CNT_W-1:0]   o_pass_cnt,
  output logic [CNT_W-1:0]   o_fail_cnt
);

  // Sum width leaves headroom for adding up to NCH events to a full counter.
  localparam int unsigned SUM_W = CNT_W + $clog2(NCH) + 1;

  localparam logic [7:0]       MIN_D   = 8'(MIN_DLY);
  localparam logic [7:0]       MAX_D   = 8'(MAX_DLY);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] CodeNone     = 2'd0;
  localparam logic [1:0] CodeCeDrop   = 2'd1;
  localparam logic [1:0] CodeCTimeout = 2'd2;
  localparam logic [1:0] CodeBMiss    = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StWaitC,
    StWaitB
  } state_e;

  // Per-channel sequence state.
  state_e     r_state [NCH];
  logic [7:0] r_dly   [NCH];

  // Registered outputs.
  logic [NCH-1:0]   r_pass_p;
  logic [NCH-1:0]   r_fail_p;
  logic [2*NCH-1:0] r_fail_code;
  logic [NCH-1:0]   r_err_sticky;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;

  // Next-state and per-edge event decode.
  state_e         w_state_nxt [NCH];
  logic [7:0]     w_dly_nxt   [NCH];
  logic [1:0]     w_code_ev   [NCH];
  logic [NCH-1:0] w_pass_ev;
  logic [NCH-1:0] w_fail_ev;

  logic [SUM_W-1:0] w_pass_sum;
  logic [SUM_W-1:0] w_fail_sum;
  logic [CNT_W-1:0] w_pass_cnt_nxt;
  logic [CNT_W-1:0] w_fail_cnt_nxt;

  // Decide each channel's transition and whether this edge passes or fails it.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_dly_nxt[i]   = r_dly[i];
      w_code_ev[i]   = CodeNone;
      w_pass_ev[i]   = 1'b0;
      w_fail_ev[i]   = 1'b0;
      case (r_state[i])
        StIdle: begin
          if (i_a[i]) begin
            if (i_ce[i]) begin
              w_state_nxt[i] = StWaitC;
              w_dly_nxt[i]   = 8'd1;
            end else begin
              // Trigger without enable fails on the trigger edge itself.
              w_fail_ev[i] = 1'b1;
              w_code_ev[i] = CodeCeDrop;
            end
          end
        end
        StWaitC: begin
          // Priority: enable loss, in-window response, timeout, keep counting.
          if (!i_ce[i]) begin
            w_fail_ev[i]   = 1'b1;
            w_code_ev[i]   = CodeCeDrop;
            w_state_nxt[i] = StIdle;
            w_dly_nxt[i]   = 8'd0;
          end else if (i_c[i] && (r_dly[i] >= MIN_D) && (r_dly[i] <= MAX_D)) begin
            // First qualifying c commits the sequence.
            w_state_nxt[i] = StWaitB;
          end else if (r_dly[i] == MAX_D) begin
            w_fail_ev[i]   = 1'b1;
            w_code_ev[i]   = CodeCTimeout;
            w_state_nxt[i] = StIdle;
            w_dly_nxt[i]   = 8'd0;
          end else begin
            w_dly_nxt[i] = r_dly[i] + 8'd1;
          end
        end
        StWaitB: begin
          w_state_nxt[i] = StIdle;
          w_dly_nxt[i]   = 8'd0;
          if (!i_ce[i]) begin
            w_fail_ev[i] = 1'b1;
            w_code_ev[i] = CodeCeDrop;
          end else if (i_b[i]) begin
            w_pass_ev[i] = 1'b1;
          end else begin
            w_fail_ev[i] = 1'b1;
            w_code_ev[i] = CodeBMiss;
          end
        end
        default: begin
          w_state_nxt[i] = StIdle;
          w_dly_nxt[i]   = 8'd0;
        end
      endcase
    end
  end

  // Add this edge's event popcounts to the totals and clamp at full scale.
  always_comb begin
    w_pass_sum = SUM_W'(r_pass_cnt);
    w_fail_sum = SUM_W'(r_fail_cnt);
    for (int i = 0; i < NCH; i++) begin
      w_pass_sum = w_pass_sum + SUM_W'(w_pass_ev[i]);
      w_fail_sum = w_fail_sum + SUM_W'(w_fail_ev[i]);
    end
    if (w_pass_sum > SUM_W'(CNT_MAX)) begin
      w_pass_cnt_nxt = CNT_MAX;
    end else begin
      w_pass_cnt_nxt = w_pass_sum[CNT_W-1:0];
    end
    if (w_fail_sum > SUM_W'(CNT_MAX)) begin
      w_fail_cnt_nxt = CNT_MAX;
    end else begin
      w_fail_cnt_nxt = w_fail_sum[CNT_W-1:0];
    end
  end

  // Channel FSM state and delay counters; reset abandons any sequence silently.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= StIdle;
        r_dly[i]   <= 8'd0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_dly[i]   <= w_dly_nxt[i];
      end
    end
  end

  // Pulses always follow the events; clr drops same-edge events from flags and totals.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pass_p     <= '0;
      r_fail_p     <= '0;
      r_fail_code  <= '0;
      r_err_sticky <= '0;
      r_pass_cnt   <= '0;
      r_fail_cnt   <= '0;
    end else begin
      r_pass_p <= w_pass_ev;
      r_fail_p <= w_fail_ev;
      if (i_clr) begin
        r_fail_code  <= '0;
        r_err_sticky <= '0;
        r_pass_cnt   <= '0;
        r_fail_cnt   <= '0;
      end else begin
        r_pass_cnt <= w_pass_cnt_nxt;
        r_fail_cnt <= w_fail_cnt_nxt;
        for (int i = 0; i < NCH; i++) begin
          if (w_fail_ev[i]) begin
            r_fail_code[2*i +: 2] <= w_code_ev[i];
            r_err_sticky[i]       <= 1'b1;
          end
        end
      end
    end
  end

  assign o_pass_p     = r_pass_p;
  assign o_fail_p     = r_fail_p;
  assign o_fail_code  = r_fail_code;
  assign o_err_sticky = r_err_sticky;
  assign o_pass_cnt   = r_pass_cnt;
  assign o_fail_cnt   = r_fail_cnt;

endmodule

// File: tb/tb_seq_window_checker.sv
// Bench for seq_window_checker: two instances (wide window with 16-bit totals, narrow
// 3..4 window with 2-bit totals) share stimulus and are checked every cycle against
// a timestamp-based model of the rule, plus literal expectations at key edges.
module tb_seq_window_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] a = '0, c = '0, b = '0, ce = '0;
  logic       clr = 1'b0;

  logic [3:0]  o0_pass_p, o0_fail_p, o0_err_sticky;
  logic [7:0]  o0_fail_code;
  logic [15:0] o0_pass_cnt, o0_fail_cnt;
  logic [3:0]  o1_pass_p, o1_fail_p, o1_err_sticky;
  logic [7:0]  o1_fail_code;
  logic [1:0]  o1_pass_cnt, o1_fail_cnt;

  always #5 clk = ~clk;

  seq_window_checker #(.NCH(4), .MIN_DLY(1), .MAX_DLY(5), .CNT_W(16)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_c(c), .i_b(b), .i_ce(ce), .i_clr(clr),
    .o_pass_p(o0_pass_p), .o_fail_p(o0_fail_p), .o_fail_code(o0_fail_code),
    .o_err_sticky(o0_err_sticky), .o_pass_cnt(o0_pass_cnt), .o_fail_cnt(o0_fail_cnt)
  );

  seq_window_checker #(.NCH(4), .MIN_DLY(3), .MAX_DLY(4), .CNT_W(2)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_c(c), .i_b(b), .i_ce(ce), .i_clr(clr),
    .o_pass_p(o1_pass_p), .o_fail_p(o1_fail_p), .o_fail_code(o1_fail_code),
    .o_err_sticky(o1_err_sticky), .o_pass_cnt(o1_pass_cnt), .o_fail_cnt(o1_fail_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: per channel, the edge number of the accepted trigger and of the
  // committing c (-1 when absent); delays are plain differences of edge numbers.
  int p_min [2] = '{1, 3};
  int p_max [2] = '{5, 4};
  int p_cw  [2] = '{16, 2};
  int cyc;
  int m_trig [2][4];
  int m_ct   [2][4];
  logic [3:0] e_pass [2], e_fail [2], e_sticky [2];
  logic [7:0] e_code [2];
  int e_pcnt [2], e_fcnt [2];

  task automatic model_reset();
    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        m_trig[d][i] = -1;
        m_ct[d][i]   = -1;
      end
      e_pass[d] = '0; e_fail[d] = '0; e_sticky[d] = '0; e_code[d] = '0;
      e_pcnt[d] = 0; e_fcnt[d] = 0;
    end
  endtask

  task automatic model_edge();
    int k, cd, np, nf, top;
    bit ps, fl;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      np = 0; nf = 0;
      for (int i = 0; i < 4; i++) begin
        ps = 0; fl = 0; cd = 0;
        if (m_trig[d][i] < 0) begin
          if (a[i]) begin
            if (ce[i]) m_trig[d][i] = cyc;
            else begin fl = 1; cd = 1; end
          end
        end else if (m_ct[d][i] < 0) begin
          k = cyc - m_trig[d][i];
          if (!ce[i]) begin fl = 1; cd = 1; m_trig[d][i] = -1; end
          else if (c[i] && k >= p_min[d] && k <= p_max[d]) m_ct[d][i] = cyc;
          else if (k >= p_max[d]) begin fl = 1; cd = 2; m_trig[d][i] = -1; end
        end else begin
          m_trig[d][i] = -1;
          m_ct[d][i]   = -1;
          if (!ce[i]) begin fl = 1; cd = 1; end
          else if (b[i]) ps = 1;
          else begin fl = 1; cd = 3; end
        end
        e_pass[d][i] = ps;
        e_fail[d][i] = fl;
        np += int'(ps);
        nf += int'(fl);
        if (fl && !clr) begin
          e_code[d][2*i +: 2] = 2'(cd);
          e_sticky[d][i] = 1'b1;
        end
      end
      top = (1 << p_cw[d]) - 1;
      if (clr) begin
        e_pcnt[d] = 0; e_fcnt[d] = 0; e_code[d] = '0; e_sticky[d] = '0;
      end else begin
        e_pcnt[d] = (e_pcnt[d] + np > top) ? top : e_pcnt[d] + np;
        e_fcnt[d] = (e_fcnt[d] + nf > top) ? top : e_fcnt[d] + nf;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_edge();
    end
  end

  // Compare every output of both instances on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("d0_pass_p", int'(o0_pass_p), int'(e_pass[0]));
      chk("d0_fail_p", int'(o0_fail_p), int'(e_fail[0]));
      chk("d0_fail_code", int'(o0_fail_code), int'(e_code[0]));
      chk("d0_err_sticky", int'(o0_err_sticky), int'(e_sticky[0]));
      chk("d0_pass_cnt", int'(o0_pass_cnt), e_pcnt[0]);
      chk("d0_fail_cnt", int'(o0_fail_cnt), e_fcnt[0]);
      chk("d1_pass_p", int'(o1_pass_p), int'(e_pass[1]));
      chk("d1_fail_p", int'(o1_fail_p), int'(e_fail[1]));
      chk("d1_fail_code", int'(o1_fail_code), int'(e_code[1]));
      chk("d1_err_sticky", int'(o1_err_sticky), int'(e_sticky[1]));
      chk("d1_pass_cnt", int'(o1_pass_cnt), e_pcnt[1]);
      chk("d1_fail_cnt", int'(o1_fail_cnt), e_fcnt[1]);
    end
  end

  // Drive inputs for one rising edge, then return just after it.
  task automatic step(input logic [3:0] ta, input logic [3:0] tc, input logic [3:0] tb,
                      input logic [3:0] tce, input logic tclr);
    a = ta; c = tc; b = tb; ce = tce; clr = tclr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(4'h0, 4'h0, 4'h0, 4'hF, 1'b0);
  endtask

  logic [3:0] r_ce;

  initial begin
    // Reset state
    idle(2);
    chk("rst_pass_cnt", int'(o0_pass_cnt), 0);
    chk("rst_fail_code", int'(o1_fail_code), 0);
    rst_n = 1'b1;
    idle(2);

    // Nominal: a at T, c at T+2, b at T+3 -> pass at T+3
    step(4'h1, 4'h0, 4'h0, 4'hF, 1'b0);
    step(4'h0, 4'h0, 4'h0, 4'hF, 1'b0);
    step(4'h0, 4'h1, 4'h0, 4'hF, 1'b0);
    step(4'h0, 4'h0, 4'h1, 4'hF, 1'b0);
    chk("nom_pass_p", int'(o0_pass_p), 1);
    chk("nom_pass_cnt", int'(o0_pass_cnt), 1);
    chk("nom_sticky", int'(o0_err_sticky), 0);
    idle(1);
    chk("nom_pulse_end", int'(o0_pass_p), 0);
    idle(3);

    // Timeout: no c, fail at T+MAX
    step(4'h0, 4'h0, 4'h0, 4'hF, 1'b1);
    step(4'h1, 4'h0, 4'h0, 4'hF, 1'b0);
    idle(4);
    chk("to_not_early", int'(o0_fail_p), 0);
    idle(1);
    chk("to_fail_p", int'(o0_fail_p), 1);
    chk("to_code", int'(o0_fail_code[1:0]), 2);
    chk("to_fail_cnt", int'(o0_fail_cnt), 1);
    chk("to_sticky", int'(o0_err_sticky[0]), 1);
    idle(2);

    // CE drop in WAIT_C, then trigger with ce low
    step(4'h0, 4'h0, 4'h0, 4'hF, 1'b1);
    step(4'h1, 4'h0, 4'h0, 4'hF, 1'b0);
    step(4'h0, 4'h0, 4'h0, 4'hF, 1'b0);
    step(4'h0, 4'h0, 4'h0, 4'hE, 1'b0);
    chk("ce_fail_p", int'(o0_fail_p), 1);
    chk("ce_code", int'(o0_fail_code[1:0]), 1);
    step(4'h1, 4'h0, 4'h0, 4'hE, 1'b0);
    chk("ce_trig_fail_p", int'(o0_fail_p), 1);
    chk("ce_trig_cnt", int'(o0_fail_cnt), 2);
    idle(2);

    // B miss then a later c/b pair must not pass (first match)
    step(4'h1, 4'h0, 4'h0, 4'hF, 1'b0);
    step(4'h0, 4'h1, 4'h0, 4'hF, 1'b0);
    step(4'h0, 4'h0, 4'h0, 4'hF, 1'b0);
    chk("bm_fail_p", int'(o0_fail_p), 1);
    chk("bm_code", int'(o0_fail_code[1:0]), 3);
    step(4'h0, 4'h1, 4'h0, 4'hF, 1'b0);
    step(4'h0, 4'h0, 4'h1, 4'hF, 1'b0);
    chk("bm_no_pass", int'(o0_pass_p), 0);
    idle(2);

    // Narrow window 3..4: c at T+2 only -> timeout at T+4
    step(4'h1, 4'h0, 4'h0, 4'hF, 1'b0);
    idle(1);
    step(4'h0, 4'h1, 4'h0, 4'hF, 1'b0);
    idle(1);
    chk("w_early_c_quiet", int'(o1_fail_p[0]), 0);
    idle(1);
    chk("w_early_c_to", int'(o1_fail_p[0]), 1);
    chk("w_early_c_code", int'(o1_fail_code[1:0]), 2);
    idle(2);
    // c at T+3 -> pass at T+4
    step(4'h1, 4'h0, 4'h0, 4'hF, 1'b0);
    idle(2);
    step(4'h0, 4'h1, 4'h0, 4'hF, 1'b0);
    step(4'h0, 4'h0, 4'h1, 4'hF, 1'b0);
    chk("w_min_pass", int'(o1_pass_p[0]), 1);
    idle(2);
    // c at T+4 -> pass at T+5
    step(4'h1, 4'h0, 4'h0, 4'hF, 1'b0);
    idle(3);
    step(4'h0, 4'h1, 4'h0, 4'hF, 1'b0);
    step(4'h0, 4'h0, 4'h1, 4'hF, 1'b0);
    chk("w_max_pass", int'(o1_pass_p[0]), 1);
    idle(2);

    // All four channels pass together: 2-bit total saturates at 3
    step(4'h0, 4'h0, 4'h0, 4'hF, 1'b1);
    step(4'hF, 4'h0, 4'h0, 4'hF, 1'b0);
    idle(2);
    step(4'h0, 4'hF, 4'h0, 4'hF, 1'b0);
    step(4'h0, 4'h0, 4'hF, 4'hF, 1'b0);
    chk("mc_pass_p", int'(o1_pass_p), 15);
    chk("mc_sat_cnt", int'(o1_pass_cnt), 3);
    chk("mc_wide_cnt", int'(o0_pass_cnt), 4);
    step(4'h0, 4'h0, 4'h0, 4'hF, 1'b1);
    chk("clr_pass_cnt", int'(o1_pass_cnt), 0);
    chk("clr_sticky", int'(o1_err_sticky), 0);
    chk("clr_code", int'(o0_fail_code), 0);
    // Event on the clr edge still pulses but is not counted
    step(4'h1, 4'h0, 4'h0, 4'hE, 1'b1);
    chk("clr_ev_fail_p", int'(o0_fail_p[0]), 1);
    chk("clr_ev_cnt", int'(o0_fail_cnt), 0);
    chk("clr_ev_sticky", int'(o0_err_sticky), 0);
    idle(2);

    // Reset while in WAIT_C abandons the sequence without a pulse
    step(4'h1, 4'h0, 4'h0, 4'hF, 1'b0);
    idle(1);
    rst_n = 1'b0;
    #2;
    chk("rst_mid_fail_p", int'(o0_fail_p), 0);
    idle(1);
    rst_n = 1'b1;
    idle(6);
    chk("rst_mid_quiet", int'(o0_fail_cnt), 0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) r_ce[i] = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      step(4'($urandom & $urandom), 4'($urandom & $urandom), 4'($urandom),
           r_ce, ($urandom_range(0, 99) == 0));
      rst_n = 1'b1;
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_window_checker.md
# seq_window_checker

Synthesizable, multi-channel RTL monitor for the protocol rule "after trigger `a`, response `c` must arrive within a programmable window, `b` must follow one cycle later, and `ce` must stay high for the whole sequence." It is the hardware successor to our simulation-only property checks. It is parametrised in channel count and window bounds, and adds failure classification, event counters and a sticky error flag so the rule can be checked on silicon or FPGA as well as in simulation. It sits beside the monitored interface, is purely observational, and never drives the monitored signals.

## Interface
- `NCH`, 4: number of independent channels.
- `MIN_DLY`, 1: earliest cycle after the trigger at which `c` is accepted (at least 1).
- `MAX_DLY`, 5: latest cycle after the trigger at which `c` is accepted (at least `MIN_DLY`, at most 255).
- `CNT_W`, 16: width of the pass and fail counters.

- `clk`  in  1  sole clock; all sampling on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a`  in  NCH  per-channel trigger.
- `c`  in  NCH  per-channel response.
- `b`  in  NCH  per-channel follow-up.
- `ce`  in  NCH  per-channel enable; must hold for the whole sequence.
- `clr`  in  1  synchronous clear of counters and sticky flags.
- `pass_p`  out  NCH  one-cycle pulse: sequence completed on that channel.
- `fail_p`  out  NCH  one-cycle pulse: sequence violated on that channel.
- `fail_code`  out  2*NCH  per-channel code of the last failure: 0 none, 1 CE_DROP, 2 C_TIMEOUT, 3 B_MISS.
- `err_sticky`  out  NCH  set on any failure; cleared only by `clr` or reset.
- `pass_cnt`  out  CNT_W  saturating total of passes across all channels.
- `fail_cnt`  out  CNT_W  saturating total of failures across all channels.

## Operation
- One FSM per channel, with states IDLE, WAIT_C and WAIT_B, plus a delay counter `dly` (8 bits).
- IDLE:
  - If `a`=1 and `ce`=1, go to WAIT_C with `dly`=1.
  - If `a`=1 and `ce`=0, fail immediately with CE_DROP and stay in IDLE.
- WAIT_C, evaluated each edge in this priority order:
  1. `ce`=0: fail CE_DROP, go to IDLE.
  2. `c`=1 and `MIN_DLY`≤`dly`≤`MAX_DLY`: go to WAIT_B.
  3. `dly`=`MAX_DLY`: fail C_TIMEOUT, go to IDLE.
  4. Otherwise: `dly`++.
  - A `c` pulse before `MIN_DLY` is ignored.
- WAIT_B:
  - `ce`=0 → fail CE_DROP.
  - `b`=1 → pass.
  - `b`=0 → fail B_MISS.
  - All three cases return to IDLE.
- Matching is first-match: the first qualifying `c` commits the sequence, and a later `c` is not tried if `b` is then missed.
- `a` seen while in WAIT_C or WAIT_B is ignored (no overlapping attempts). A new trigger is accepted only from IDLE, so it is not accepted on the same edge that returns a channel to IDLE.
- Counters:
  - `pass_cnt` adds popcount(pass events this cycle) and saturates at 2^CNT_W−1. `fail_cnt` does the same for fail events.
  - Addition uses width CNT_W+$clog2(NCH)+1 and is then clamped.
- `clr`:
  - Zeroes both counters and `err_sticky`, and sets `fail_code` to 0.
  - Does not touch the FSMs.
  - Events decided on the same edge as `clr` are dropped from the counters and flags.
  - `pass_p` and `fail_p` still pulse on that edge.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - All FSMs go to IDLE and `dly` to 0.
  - `pass_p`, `fail_p`, `fail_code`, `err_sticky`, `pass_cnt` and `fail_cnt` are all 0.
  - Reset mid-sequence abandons the sequence silently, with no pulse.
- All outputs are registered and update on the deciding edge. A pulse is high for exactly one cycle after that edge.
- Latency, with the trigger sampled at edge T:
  - Earliest pass is at edge T+MIN_DLY+1.
  - C_TIMEOUT is reported at edge T+MAX_DLY.
  - CE_DROP is reported at the edge where `ce`=0 is sampled.
- `ce` is checked at edge T and at every edge through the `b` edge inclusive.
- `pass_p` and `fail_p` for the same channel are never high together.
- Channels are fully independent. Simultaneous events on several channels are all counted in the same cycle.

## Test plan
- Nominal, with NCH=1, MIN=1, MAX=5:
  - Stimulus: `a` at edge 2, `c` at edge 4, `b` at edge 5, `ce` high over edges 1–7.
  - Required: `pass_p` at edge 5, `pass_cnt`=1, `err_sticky`=0.
- Timeout:
  - Stimulus: `a` at edge 2, no `c`.
  - Required: `fail_p` at edge 7, `fail_code`=2, `fail_cnt`=1, `err_sticky`=1.
- CE drop:
  - Stimulus: `a` at edge 2, `ce`=0 at edge 4.
  - Required: `fail_p` at edge 4 with code 1.
  - Also: `a` with `ce`=0 gives `fail_p` on the trigger edge.
- B miss and first-match:
  - Stimulus: `c` at edges 3 and 5, `b` low at edge 4, `b` high at edge 6.
  - Required: `fail_p` at edge 4 with code 3; no pass at edge 6.
- Window bounds, with MIN=3, MAX=4:
  - `c` only at T+2: timeout at T+4.
  - `c` at T+3: pass at T+4.
  - `c` at T+4: pass at T+5.
- Multi-channel, saturation, clear and reset, with NCH=4, CNT_W=2:
  - Simultaneous passes on all four channels give `pass_cnt`=3 (saturated).
  - `clr` zeroes the counters and flags.
  - `rst_n` low in WAIT_C puts that channel in IDLE with no pulse.
